// File: rtl/ex_alu1_writeback_receiver.sv
// ALU1 writeback receiver. It buffers every execute-port result beat in a FIFO and drains one
// per cycle into the register/flag write ports and the commit-done notify.
module ex_alu1_writeback_receiver #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DEPTH_N = 3
) (
  input  logic               iCLOCK,
  input  logic               iRESET,
  input  logic               iFREE_EX,
  input  logic               iEX_ALU1_VALID,
  input  logic [5:0]         iEX_ALU1_COMMIT_TAG,
  input  logic               iEX_ALU1_SYSREG,
  input  logic [5:0]         iEX_ALU1_DESTINATION_REGNAME,
  input  logic               iEX_ALU1_WRITEBACK,
  input  logic [31:0]        iEX_ALU1_DATA,
  input  logic [4:0]         iEX_ALU1_FLAG,
  input  logic               iEX_ALU1_FLAGS_WRITEBACK,
  input  logic [3:0]         iEX_ALU1_FLAGS_REGNAME,
  output logic               oWB_VALID,
  input  logic               iWB_BUSY,
  output logic               oWB_GPR_WR,
  output logic               oWB_SPR_WR,
  output logic [5:0]         oWB_REGNAME,
  output logic [31:0]        oWB_DATA,
  output logic               oWB_FLAG_WR,
  output logic [3:0]         oWB_FLAGS_REGNAME,
  output logic [4:0]         oWB_FLAG,
  output logic               oCOMMIT_DONE,
  output logic [5:0]         oCOMMIT_TAG,
  output logic [DEPTH_N:0]   oCOUNT,
  output logic               oOVERFLOW
);

  typedef struct packed {
    logic [5:0]  tag;
    logic        sysreg;
    logic [5:0]  regname;
    logic        writeback;
    logic [31:0] data;
    logic [4:0]  flag;
    logic        flags_writeback;
    logic [3:0]  flags_regname;
  } entry_t;

  localparam logic [DEPTH_N-1:0] PtrOne    = {{(DEPTH_N-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_N:0]   CountOne  = {{DEPTH_N{1'b0}}, 1'b1};
  localparam logic [DEPTH_N:0]   CountFull = DEPTH[DEPTH_N:0];

  entry_t               mem_q [DEPTH];
  logic [DEPTH_N-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_N:0]     count_q, count_d;
  logic                 done_q, done_d, ovf_q, ovf_d;
  logic [5:0]           tag_q, tag_d;
  logic                 full, wb_valid, push, pop;
  entry_t               head, in_entry;

  assign in_entry = '{
    tag:             iEX_ALU1_COMMIT_TAG,
    sysreg:          iEX_ALU1_SYSREG,
    regname:         iEX_ALU1_DESTINATION_REGNAME,
    writeback:       iEX_ALU1_WRITEBACK,
    data:            iEX_ALU1_DATA,
    flag:            iEX_ALU1_FLAG,
    flags_writeback: iEX_ALU1_FLAGS_WRITEBACK,
    flags_regname:   iEX_ALU1_FLAGS_REGNAME
  };

  assign head     = mem_q[rd_ptr_q];
  assign full     = (count_q == CountFull);
  assign wb_valid = (count_q != '0);
  assign pop      = wb_valid && !iWB_BUSY && !iFREE_EX;
  // A full FIFO still accepts a beat when the head retires in the same cycle.
  assign push     = iEX_ALU1_VALID && !iFREE_EX && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    done_d   = 1'b0;
    tag_d    = tag_q;
    ovf_d    = ovf_q;
    if (iFREE_EX) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      done_d = pop;
      if (pop) begin
        tag_d    = head.tag;
        rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (push && !pop) count_d = count_q + CountOne;
      else if (pop && !push) count_d = count_q - CountOne;
      if (iEX_ALU1_VALID && full && !pop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      done_q   <= 1'b0;
      tag_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      done_q   <= done_d;
      tag_q    <= tag_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= in_entry;
    end
  end

  // Head fields come straight from storage, gated so the port reads all-zero when empty.
  assign oWB_VALID         = wb_valid;
  assign oWB_GPR_WR        = wb_valid && !head.sysreg && head.writeback;
  assign oWB_SPR_WR        = wb_valid && head.sysreg && head.writeback;
  assign oWB_REGNAME       = head.regname & {6{wb_valid}};
  assign oWB_DATA          = head.data & {32{wb_valid}};
  assign oWB_FLAG_WR       = wb_valid && head.flags_writeback;
  assign oWB_FLAGS_REGNAME = head.flags_regname & {4{wb_valid}};
  assign oWB_FLAG          = head.flag & {5{wb_valid}};
  assign oCOMMIT_DONE      = done_q;
  assign oCOMMIT_TAG       = tag_q;
  assign oCOUNT            = count_q;
  assign oOVERFLOW         = ovf_q;

endmodule
